// File: rtl/cpu_run_controller.sv
// Run controller for the CPU under test: sequences CPU reset and clock enable,
// watches cpu_active until halt, counts run cycles, enforces a timeout and captures results.
//
// state | meaning
// IDLE  | waiting for start; previous status/cycle_count/watch_out held
// RST   | cpu_reset high for RESET_CYCLES cycles
// ARM   | single cycle with clock enabled; cpu_active checked at its closing edge
// RUN   | CPU executing; counting cycles until halt, abort or timeout
module cpu_run_controller #(
  parameter int RESET_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32,
  parameter int NUM_WATCH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cpu_active,
  input  logic [32*NUM_WATCH-1:0]   watch_in,
  output logic                      cpu_reset,
  output logic                      cpu_clk_enable,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                status,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [32*NUM_WATCH-1:0]   watch_out
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] ST_NONE       = 3'd0;
  localparam logic [2:0] ST_OK         = 3'd1;
  localparam logic [2:0] ST_TIMEOUT    = 3'd2;
  localparam logic [2:0] ST_NOT_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ABORTED    = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_ARM, S_RUN} state_t;

  state_t                    state, state_nxt;
  logic [RST_W-1:0]          rst_cnt, rst_cnt_nxt;
  logic                      cpu_reset_nxt, clk_en_nxt, done_nxt;
  logic [2:0]                status_nxt;
  logic [CNT_W-1:0]          count_nxt, count_inc;
  logic [32*NUM_WATCH-1:0]   watch_nxt;
  logic                      timeout_hit, start_ok;

  assign count_inc   = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);
  assign start_ok    = start && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      rst_cnt        <= '0;
      cpu_reset      <= 1'b0;
      cpu_clk_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      status         <= ST_NONE;
      cycle_count    <= '0;
      watch_out      <= '0;
    end else begin
      state          <= state_nxt;
      rst_cnt        <= rst_cnt_nxt;
      cpu_reset      <= cpu_reset_nxt;
      cpu_clk_enable <= clk_en_nxt;
      busy           <= (state_nxt != S_IDLE);
      done           <= done_nxt;
      status         <= status_nxt;
      cycle_count    <= count_nxt;
      watch_out      <= watch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_RST;
      S_RST: begin
        if (abort)             state_nxt = S_IDLE;
        else if (rst_cnt == '0) state_nxt = S_ARM;
      end
      S_ARM:  state_nxt = (!abort && cpu_active) ? S_RUN : S_IDLE;
      S_RUN:  if (abort || !cpu_active || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Computes the registered output values for the coming edge.
  always_comb begin
    rst_cnt_nxt   = rst_cnt;
    cpu_reset_nxt = 1'b0;
    clk_en_nxt    = 1'b0;
    done_nxt      = 1'b0;
    status_nxt    = status;
    count_nxt     = cycle_count;
    watch_nxt     = watch_out;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          cpu_reset_nxt = 1'b1;
          status_nxt    = ST_NONE;
          count_nxt     = '0;
          watch_nxt     = '0;
          rst_cnt_nxt   = RST_LOAD;
        end
      end
      S_RST: begin
        if (abort) begin
          done_nxt   = 1'b1;
          status_nxt = ST_ABORTED;
        end else if (rst_cnt == '0) begin
          clk_en_nxt = 1'b1;
        end else begin
          cpu_reset_nxt = 1'b1;
          rst_cnt_nxt   = rst_cnt - RST_W'(1);
        end
      end
      S_ARM: begin
        if (abort) begin
          done_nxt   = 1'b1;
          status_nxt = ST_ABORTED;
        end else if (cpu_active) begin
          clk_en_nxt = 1'b1;
        end else begin
          done_nxt   = 1'b1;
          status_nxt = ST_NOT_ACTIVE;
        end
      end
      S_RUN: begin
        if (abort) begin
          done_nxt   = 1'b1;
          status_nxt = ST_ABORTED;
        end else if (!cpu_active) begin
          done_nxt   = 1'b1;
          status_nxt = ST_OK;
          watch_nxt  = watch_in;
        end else if (timeout_hit) begin
          done_nxt   = 1'b1;
          status_nxt = ST_TIMEOUT;
          count_nxt  = count_inc;
          watch_nxt  = watch_in;
        end else begin
          clk_en_nxt = 1'b1;
          count_nxt  = count_inc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: a default instance and a
// 3-bit-counter, no-timeout instance, each driven by a small CPU model.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset, start, abort, b_start;
  logic [63:0] watch_in;

  logic        a_active, a_cpu_reset, a_clk_en, a_busy, a_done;
  logic [2:0]  a_status;
  logic [31:0] a_count;
  logic [63:0] a_watch;

  logic        b_active, b_cpu_reset, b_clk_en, b_busy, b_done;
  logic [2:0]  b_status;
  logic [2:0]  b_count;
  logic [63:0] b_watch;

  always #5 clk = ~clk;

  cpu_run_controller dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cpu_active(a_active), .watch_in(watch_in),
    .cpu_reset(a_cpu_reset), .cpu_clk_enable(a_clk_en), .busy(a_busy),
    .done(a_done), .status(a_status), .cycle_count(a_count), .watch_out(a_watch)
  );

  cpu_run_controller #(.RESET_CYCLES(1), .TIMEOUT_CYCLES(0), .CNT_W(3), .NUM_WATCH(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(1'b0),
    .cpu_active(b_active), .watch_in(watch_in),
    .cpu_reset(b_cpu_reset), .cpu_clk_enable(b_clk_en), .busy(b_busy),
    .done(b_done), .status(b_status), .cycle_count(b_count), .watch_out(b_watch)
  );

  // CPU model: goes active while held in reset (if m_go), halts once m_halt enabled cycles have elapsed.
  logic m_go_a = 1'b0, m_run_a = 1'b0, m_go_b = 1'b0, m_run_b = 1'b0;
  int   m_halt_a = 0, m_cyc_a = 0, m_halt_b = 0, m_cyc_b = 0;
  int   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_cpu_reset) begin
      m_run_a <= m_go_a;
      m_cyc_a <= 0;
    end else if (a_clk_en) begin
      m_cyc_a <= m_cyc_a + 1;
      if (m_cyc_a == m_halt_a) m_run_a <= 1'b0;
    end
    if (b_cpu_reset) begin
      m_run_b <= m_go_b;
      m_cyc_b <= 0;
    end else if (b_clk_en) begin
      m_cyc_b <= m_cyc_b + 1;
      if (m_cyc_b == m_halt_b) m_run_b <= 1'b0;
    end
  end
  assign a_active = m_run_a;
  assign b_active = m_run_b;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cnt;
    logic [63:0] w;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   start_a = 0, start_b = 0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 64'(a_done), 64'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_status",  64'(a_status), 64'(ea.st));
        chk("a_count",   64'(a_count),  64'(ea.cnt));
        chk("a_watch",   a_watch,       ea.w);
        chk("a_latency", 64'(cyc - start_a), 64'(ea.lat));
      end
    end
    if (reset === 1'b1) chk("a_rst_en_exclusive", 64'(a_cpu_reset & a_clk_en), 64'd0);
  end

  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 64'(b_done), 64'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_status",  64'(b_status), 64'(eb.st));
        chk("b_count",   64'(b_count),  64'(eb.cnt));
        chk("b_watch",   b_watch,       eb.w);
        chk("b_latency", 64'(cyc - start_b), 64'(eb.lat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_a(input logic go, input int halt, input logic push,
                       input logic [2:0] st, input logic [31:0] cnt, input logic [63:0] w, input int lat);
    exp_t e;
    m_go_a   = go;
    m_halt_a = halt;
    e.st = st; e.cnt = cnt; e.w = w; e.lat = lat;
    if (push) qa.push_back(e);
    start_a = cyc + 1;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int k = 0;
    while (a_done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    if (a_done !== 1'b1) chk("a_done_wait_expired", 64'(a_done), 64'd1);
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_cpu_reset"}, 64'(a_cpu_reset), 64'd0);
    chk({tag, "_clk_en"},    64'(a_clk_en),    64'd0);
    chk({tag, "_busy"},      64'(a_busy),      64'd0);
    chk({tag, "_done"},      64'(a_done),      64'd0);
    chk({tag, "_status"},    64'(a_status),    64'd0);
    chk({tag, "_count"},     64'(a_count),     64'd0);
    chk({tag, "_watch"},     a_watch,          64'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0; start = 1'b0; abort = 1'b0; b_start = 1'b0; watch_in = '0;
    tick(2);
    check_a_zero("rst");
    chk("rst_b_status", 64'(b_status), 64'd0);
    chk("rst_b_count",  64'(b_count),  64'd0);
    reset = 1'b1;
    tick(1);

    // Normal halt after 5 RUN cycles
    watch_in = {32'h3, 32'h2A};
    run_a(1'b1, 5, 1'b1, 3'd1, 32'd5, {32'h3, 32'h2A}, 8);
    chk("norm_cpu_reset_hi", 64'(a_cpu_reset), 64'd1);
    chk("norm_busy",         64'(a_busy),      64'd1);
    chk("norm_status_clr",   64'(a_status),    64'd0);
    tick(1);
    chk("norm_cpu_reset_lo", 64'(a_cpu_reset), 64'd0);
    chk("norm_clk_en_arm",   64'(a_clk_en),    64'd1);
    wait_done_a(30);
    chk("norm_busy_at_done", 64'(a_busy), 64'd0);
    tick(1);
    chk("norm_done_one_cycle", 64'(a_done), 64'd0);

    // Timeout: CPU never halts
    watch_in = {32'h11, 32'h22};
    run_a(1'b1, 1000, 1'b1, 3'd2, 32'd15, {32'h11, 32'h22}, 17);
    wait_done_a(40);
    chk("to_clk_en_off", 64'(a_clk_en), 64'd0);
    tick(1);

    // CPU never becomes active
    run_a(1'b0, 0, 1'b1, 3'd3, 32'd0, 64'd0, 2);
    wait_done_a(20);
    tick(1);

    // Abort at RUN cycle 3 with an ignored start during RUN
    watch_in = {32'hDEAD, 32'hBEEF};
    run_a(1'b1, 1000, 1'b1, 3'd4, 32'd3, 64'd0, 6);
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_start_cpu_reset", 64'(a_cpu_reset), 64'd0);
    chk("ign_start_busy",      64'(a_busy),      64'd1);
    tick(1);
    chk("abort_pre_count", 64'(a_count), 64'd3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);

    // Async reset in the middle of RUN
    run_a(1'b1, 1000, 1'b0, 3'd0, 32'd0, 64'd0, 0);
    tick(5);
    chk("mid_busy_before", 64'(a_busy), 64'd1);
    #2 reset = 1'b0;
    #1 check_a_zero("midrst");
    tick(1);
    reset = 1'b1;
    tick(1);

    // Full run after reset, then a back-to-back run
    watch_in = {32'h7, 32'h9};
    run_a(1'b1, 5, 1'b1, 3'd1, 32'd5, {32'h7, 32'h9}, 8);
    wait_done_a(30);
    tick(2);
    chk("idle_status_held", 64'(a_status), 64'd1);
    watch_in = {32'hA, 32'hB};
    run_a(1'b1, 2, 1'b1, 3'd1, 32'd2, {32'hA, 32'hB}, 5);
    chk("b2b_status_clr", 64'(a_status), 64'd0);
    chk("b2b_count_clr",  64'(a_count),  64'd0);
    chk("b2b_busy",       64'(a_busy),   64'd1);
    wait_done_a(30);
    tick(1);

    // Saturating 3-bit counter, no timeout
    watch_in = {32'h5, 32'h6};
    m_go_b = 1'b1;
    m_halt_b = 10;
    eb.st = 3'd1; eb.cnt = 32'd7; eb.w = {32'h5, 32'h6}; eb.lat = 13;
    qb.push_back(eb);
    start_b = cyc + 1;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    k = 0;
    while (b_done !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    if (b_done !== 1'b1) chk("b_done_wait_expired", 64'(b_done), 64'd1);
    tick(2);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

endmodule
